// File: rtl/ghost_pkg.sv
// ghost_pkg: shared state type, ghost indices and
// per-ghost home / patrol rectangle / release constants.
package ghost_pkg;

  typedef enum logic [2:0] {
    HOME,
    EXIT,
    PATROL_R,
    PATROL_D,
    PATROL_L,
    PATROL_U
  } ghost_state_t;

  typedef logic [8:0] coord_t;

  localparam int NUM_GHOSTS = 4;
  localparam int GHOST_RED = 0;
  localparam int GHOST_PINK = 1;
  localparam int GHOST_CYAN = 2;
  localparam int GHOST_YELLOW = 3;

  localparam coord_t HOME_X [NUM_GHOSTS] =
    '{9'd104, 9'd112, 9'd120, 9'd128};
  localparam coord_t HOME_Y [NUM_GHOSTS] =
    '{9'd100, 9'd100, 9'd100, 9'd100};
  localparam coord_t X_MIN [NUM_GHOSTS] =
    '{9'd16, 9'd40, 9'd24, 9'd8};
  localparam coord_t X_MAX [NUM_GHOSTS] =
    '{9'd232, 9'd200, 9'd216, 9'd248};
  localparam coord_t Y_MIN [NUM_GHOSTS] =
    '{9'd40, 9'd60, 9'd80, 9'd20};
  localparam coord_t Y_MAX [NUM_GHOSTS] =
    '{9'd200, 9'd180, 9'd240, 9'd260};
  localparam logic [7:0] RELEASE [NUM_GHOSTS] =
    '{8'd0, 8'd60, 8'd120, 8'd180};

endpackage

// File: rtl/ghost_motion_ctrl_if.sv
// ghost_motion_ctrl_if: ghost position bundle toward the sprite renderer.
// master = position producer, slave = renderer.
interface ghost_motion_ctrl_if;
  logic [8:0] x_red;
  logic [8:0] y_red;
  logic [8:0] x_pink;
  logic [8:0] y_pink;
  logic [8:0] x_blue;
  logic [8:0] y_blue;
  logic [8:0] x_yellow;
  logic [8:0] y_yellow;
  logic [3:0] ghost_active;

  modport master (
    output x_red, y_red, x_pink, y_pink,
    output x_blue, y_blue, x_yellow, y_yellow,
    output ghost_active
  );

  modport slave (
    input x_red, y_red, x_pink, y_pink,
    input x_blue, y_blue, x_yellow, y_yellow,
    input ghost_active
  );
endinterface

// File: rtl/ghost_walker.sv
// ghost_walker: one ghost FSM (home, exit, clockwise patrol) with x/y regs.
// Ports: clk, rst (async low), step, release_ok, restart -> x, y, active.
module ghost_walker
  import ghost_pkg::*;
#(
  parameter coord_t HX = 9'd104,
  parameter coord_t HY = 9'd100,
  parameter coord_t XMIN = 9'd16,
  parameter coord_t XMAX = 9'd232,
  parameter coord_t YMIN = 9'd40,
  parameter coord_t YMAX = 9'd200
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  input  logic   release_ok,
  input  logic   restart,
  output coord_t x,
  output coord_t y,
  output logic   active
);

  ghost_state_t state_q, state_d;
  coord_t x_d, y_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HOME;
      x <= HX;
      y <= HY;
      active <= 1'b0;
    end else begin
      state_q <= state_d;
      x <= x_d;
      y <= y_d;
      active <= (state_d != HOME);
    end
  end

  // Limit checks use the pre-step coordinate so the corner
  // move itself is the first pixel of the next edge.
  always_comb begin
    state_d = state_q;
    x_d = x;
    y_d = y;
    if (restart) begin
      state_d = HOME;
      x_d = HX;
      y_d = HY;
    end else if (step) begin
      unique case (state_q)
        HOME: begin
          if (release_ok) begin
            state_d = EXIT;
            y_d = y - 9'd1;
          end
        end
        EXIT, PATROL_U: begin
          if (y == YMIN) begin
            state_d = PATROL_R;
            x_d = x + 9'd1;
          end else begin
            y_d = y - 9'd1;
          end
        end
        PATROL_R: begin
          if (x == XMAX) begin
            state_d = PATROL_D;
            y_d = y + 9'd1;
          end else begin
            x_d = x + 9'd1;
          end
        end
        PATROL_D: begin
          if (y == YMAX) begin
            state_d = PATROL_L;
            x_d = x - 9'd1;
          end else begin
            y_d = y + 9'd1;
          end
        end
        PATROL_L: begin
          if (x == XMIN) begin
            state_d = PATROL_U;
            y_d = y - 9'd1;
          end else begin
            x_d = x - 9'd1;
          end
        end
        default: begin
          state_d = HOME;
          x_d = HX;
          y_d = HY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ghost_motion_ctrl.sv
// ghost_motion_ctrl: frame/release counters and four ghost walkers.
// Ports: clk, rst (async low), frame_start, pause, restart -> pos (master).
module ghost_motion_ctrl
  import ghost_pkg::*;
#(
  parameter int STEP_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic pause,
  input  logic restart,
  ghost_motion_ctrl_if.master pos
);

  localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);

  logic [3:0] frame_cnt;
  logic [7:0] release_cnt;
  logic [7:0] release_nxt;
  logic frame_ev;
  logic step;
  coord_t gx [NUM_GHOSTS];
  coord_t gy [NUM_GHOSTS];
  logic [NUM_GHOSTS-1:0] act;

  assign frame_ev = frame_start & ~pause;
  assign step = frame_ev & (frame_cnt == DIV_LAST);
  assign release_nxt = (release_cnt == 8'hff) ?
    release_cnt : release_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      release_cnt <= '0;
    end else if (restart) begin
      frame_cnt <= '0;
      release_cnt <= '0;
    end else if (frame_ev) begin
      frame_cnt <= (frame_cnt == DIV_LAST) ?
        4'd0 : frame_cnt + 4'd1;
      release_cnt <= release_nxt;
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_walk
    ghost_walker #(
      .HX(HOME_X[g]),
      .HY(HOME_Y[g]),
      .XMIN(X_MIN[g]),
      .XMAX(X_MAX[g]),
      .YMIN(Y_MIN[g]),
      .YMAX(Y_MAX[g])
    ) u_walker (
      .clk(clk),
      .rst(rst),
      .step(step),
      .release_ok(release_nxt >= RELEASE[g]),
      .restart(restart),
      .x(gx[g]),
      .y(gy[g]),
      .active(act[g])
    );
  end

  assign pos.x_red = gx[GHOST_RED];
  assign pos.y_red = gy[GHOST_RED];
  assign pos.x_pink = gx[GHOST_PINK];
  assign pos.y_pink = gy[GHOST_PINK];
  assign pos.x_blue = gx[GHOST_CYAN];
  assign pos.y_blue = gy[GHOST_CYAN];
  assign pos.x_yellow = gx[GHOST_YELLOW];
  assign pos.y_yellow = gy[GHOST_YELLOW];
  assign pos.ghost_active = act;

endmodule
